// File: rtl/scan_mux.sv
// scan_mux: registered N:1 channel mux with manual select and a timed auto-scan sequencer.
module scan_mux #(
   parameter int N_CH    = 16,
   parameter int DW      = 1,
   parameter int SEL_W   = 4,
   parameter int DWELL_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_CH*DW-1:0]   ins,
   input  logic                 mode,
   input  logic [SEL_W-1:0]     sel_in,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 cont,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [DW-1:0]        y,
   output logic                 y_valid,
   output logic [SEL_W-1:0]     cur_sel,
   output logic                 busy,
   output logic                 wrap
);
   typedef enum logic {IDLE, SCAN} state_t;
   state_t state, state_d;
   logic [DW-1:0] y_d, man_y, scan_y;
   logic y_valid_d, wrap_d, last;
   logic [SEL_W-1:0] sel_d;
   logic [DWELL_W-1:0] dcnt, dcnt_d, dwell_q, dwell_q_d;
   // Compare-based muxes so selects at or beyond N_CH read as zero.
   always_comb begin
      man_y = '0;
      scan_y = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (sel_in == SEL_W'(i)) man_y = ins[i*DW +: DW];
         if (cur_sel == SEL_W'(i)) scan_y = ins[i*DW +: DW];
      end
   end
   assign last = cur_sel == SEL_W'(N_CH-1);
   assign busy = state == SCAN;
   always_comb begin
      state_d = state;
      sel_d = cur_sel;
      y_d = y;
      y_valid_d = 1'b0;
      wrap_d = 1'b0;
      dcnt_d = dcnt;
      dwell_q_d = dwell_q;
      if (state == IDLE) begin
         if (!mode) begin
            sel_d = sel_in;
            y_d = man_y;
            y_valid_d = 1'b1;
         end else if (start && !stop) begin
            state_d = SCAN;
            sel_d = '0;
            dcnt_d = '0;
            dwell_q_d = dwell;
         end
      end else if (stop) begin
         state_d = IDLE;
         sel_d = '0;
      end else if (dcnt == dwell_q) begin
         y_d = scan_y;
         y_valid_d = 1'b1;
         dcnt_d = '0;
         wrap_d = last;
         sel_d = last ? '0 : cur_sel + 1'b1;
         state_d = (last && !cont) ? IDLE : SCAN;
      end else begin
         dcnt_d = dcnt + 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cur_sel <= '0;
         y <= '0;
         y_valid <= 1'b0;
         wrap <= 1'b0;
         dcnt <= '0;
         dwell_q <= '0;
      end else begin
         state <= state_d;
         cur_sel <= sel_d;
         y <= y_d;
         y_valid <= y_valid_d;
         wrap <= wrap_d;
         dcnt <= dcnt_d;
         dwell_q <= dwell_q_d;
      end
   end
endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: directed bench for a 16x1 and a 5x4 scan_mux with a sample scoreboard.
module tb_scan_mux;
   logic clk = 1'b0;
   logic rst_n;
   logic [15:0] a_ins;
   logic a_mode, a_start, a_stop, a_cont, a_y, a_v, a_busy, a_wrap;
   logic [3:0] a_sel, a_cur;
   logic [7:0] a_dwell;
   logic [19:0] b_ins;
   logic b_mode, b_start, b_stop, b_cont, b_v, b_busy, b_wrap;
   logic [2:0] b_sel, b_cur;
   logic [3:0] b_y;
   logic [7:0] b_dwell;
   logic [15:0] pat;
   logic [31:0] sb[$];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   scan_mux #(.N_CH(16), .DW(1), .SEL_W(4), .DWELL_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .ins(a_ins), .mode(a_mode), .sel_in(a_sel),
      .start(a_start), .stop(a_stop), .cont(a_cont), .dwell(a_dwell),
      .y(a_y), .y_valid(a_v), .cur_sel(a_cur), .busy(a_busy), .wrap(a_wrap));

   scan_mux #(.N_CH(5), .DW(4), .SEL_W(3), .DWELL_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .ins(b_ins), .mode(b_mode), .sel_in(b_sel),
      .start(b_start), .stop(b_stop), .cont(b_cont), .dwell(b_dwell),
      .y(b_y), .y_valid(b_v), .cur_sel(b_cur), .busy(b_busy), .wrap(b_wrap));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input string tag, input logic [31:0] obs);
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $error("FAIL %s: observed sample %0h expected none queued", tag, obs);
      end else begin
         chk(tag, obs, sb.pop_front());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_ins = 16'h30cf; a_mode = 1'b0; a_sel = '0; a_start = 1'b0; a_stop = 1'b0;
      a_cont = 1'b0; a_dwell = '0;
      b_ins = 20'h54321; b_mode = 1'b0; b_sel = '0; b_start = 1'b0; b_stop = 1'b0;
      b_cont = 1'b0; b_dwell = '0;
      pat = 16'b0011_0000_1100_1111;
      #2;
      chk("rst_y", a_y, 0); chk("rst_v", a_v, 0); chk("rst_cur", a_cur, 0);
      chk("rst_busy", a_busy, 0); chk("rst_wrap", a_wrap, 0);
      #6 rst_n = 1'b1;
      // manual sweep
      for (int s = 0; s < 16; s++) begin
         a_sel = 4'(s);
         sb.push_back({31'd0, pat[s]});
         tick();
         chk("man_v", a_v, 1);
         sb_pop("man_y", a_y);
         chk("man_cur", a_cur, s);
      end
      // single auto sweep, dwell 0
      a_mode = 1'b1; a_start = 1'b1; a_dwell = 8'd0; a_cont = 1'b0;
      tick();
      a_start = 1'b0;
      chk("a1_busy0", a_busy, 1); chk("a1_v0", a_v, 0); chk("a1_cur0", a_cur, 0);
      for (int c = 0; c < 16; c++) sb.push_back({31'd0, pat[c]});
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("a1_v", a_v, 1);
         sb_pop("a1_y", a_y);
         chk("a1_wrap", a_wrap, i == 15);
         chk("a1_busy", a_busy, i != 15);
      end
      chk("a1_cur_end", a_cur, 0);
      tick();
      chk("a1_idle_v", a_v, 0); chk("a1_idle_y", a_y, pat[15]);
      // continuous sweep, dwell 3, dwell changed mid-sweep
      a_dwell = 8'd3; a_cont = 1'b1; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int j = 0; j < 32; j++) sb.push_back({31'd0, pat[j % 16]});
      for (int i = 1; i <= 128; i++) begin
         if (i == 10) a_dwell = 8'd0;
         tick();
         chk("dw_v", a_v, (i % 4) == 0);
         if (a_v) sb_pop("dw_y", a_y);
         chk("dw_wrap", a_wrap, (i % 64) == 0);
         chk("dw_busy", a_busy, 1);
      end
      chk("dw_sb_left", sb.size(), 0);
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      chk("dw_stop_busy", a_busy, 0); chk("dw_stop_cur", a_cur, 0);
      // stop mid-sweep at cur_sel 5
      a_ins = 16'h0010; a_cont = 1'b0; a_dwell = 8'd0; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int c = 0; c < 5; c++) sb.push_back(c == 4 ? 32'd1 : 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("st_v", a_v, 1);
         sb_pop("st_y", a_y);
      end
      chk("st_cur5", a_cur, 5);
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      chk("st_busy", a_busy, 0); chk("st_cur", a_cur, 0);
      chk("st_v_off", a_v, 0); chk("st_y_hold", a_y, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("st_quiet_v", a_v, 0); chk("st_quiet_y", a_y, 1);
      end
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("rs_busy", a_busy, 1); chk("rs_cur", a_cur, 0);
      sb.push_back(32'd0);
      tick();
      chk("rs_v", a_v, 1); sb_pop("rs_y", a_y); chk("rs_cur1", a_cur, 1);
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      // asynchronous reset during SCAN
      a_ins = 16'hffff; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("ar_pre_busy", a_busy, 1); chk("ar_pre_y", a_y, 1); chk("ar_pre_cur", a_cur, 3);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_y", a_y, 0); chk("ar_v", a_v, 0); chk("ar_cur", a_cur, 0);
      chk("ar_busy", a_busy, 0); chk("ar_wrap", a_wrap, 0);
      #10 rst_n = 1'b1;
      tick();
      chk("ar_idle_busy", a_busy, 0); chk("ar_idle_v", a_v, 0); chk("ar_idle_cur", a_cur, 0);
      tick();
      chk("ar_idle_busy2", a_busy, 0);
      a_start = 1'b1;
      tick();
      a_start = 1'b0;
      chk("ar_start_busy", a_busy, 1);
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      // 5-channel, 4-bit instance
      b_mode = 1'b1; b_dwell = 8'd0; b_cont = 1'b0; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int c = 0; c < 5; c++) sb.push_back(32'(c + 1));
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("b_v", b_v, 1);
         sb_pop("b_y", b_y);
         chk("b_wrap", b_wrap, i == 4);
         chk("b_cur", b_cur, (i + 1) % 5);
         chk("b_cur_rng", b_cur <= 3'd4, 1);
      end
      chk("b_busy_end", b_busy, 0);
      b_mode = 1'b0; b_sel = 3'd7;
      tick();
      chk("b_man7_y", b_y, 0); chk("b_man7_v", b_v, 1); chk("b_man7_cur", b_cur, 7);
      b_sel = 3'd3;
      tick();
      chk("b_man3_y", b_y, 4);
      b_mode = 1'b1; b_start = 1'b1; b_stop = 1'b1;
      tick();
      chk("b_ss_busy", b_busy, 0); chk("b_ss_v", b_v, 0);
      b_start = 1'b0; b_stop = 1'b0;
      tick();
      chk("b_ss_busy2", b_busy, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
